// File: rtl/range_scan_if.sv
// Result port of range_scan: valid/ready handshake carrying the scan summary.
interface range_scan_if #(
  parameter int RAM_ADDR_BITS = 4
);
  logic                      res_valid;
  logic                      res_ready;
  logic [15:0]               max_count;
  logic [31:0]               max_n;
  logic [15:0]               min_count;
  logic [16+RAM_ADDR_BITS-1:0] sum_count;
  logic                      timeout;

  modport master (
    output res_valid, max_count, max_n, min_count, sum_count, timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid, max_count, max_n, min_count, sum_count, timeout,
    output res_ready
  );
endinterface

// File: rtl/range_scan.sv
// Launches the `range` Collatz block, streams its count RAM and reduces it to max/argmax/min/sum.
// Optional WAIT watchdog enabled by defining SCAN_TIMEOUT_EN.
module range_scan #(
  parameter int RAM_WORDS      = 16,
  parameter int RAM_ADDR_BITS  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [31:0]         base,
  output logic                busy,
  range_scan_if.master        res,
  output logic                r_go,
  output logic [31:0]         r_start,
  input  logic                r_done,
  input  logic [15:0]         r_count
);

  localparam int SUM_W = 16 + RAM_ADDR_BITS;

  if ($clog2(RAM_WORDS) != RAM_ADDR_BITS || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("range_scan: inconsistent RAM_WORDS/RAM_ADDR_BITS or TIMEOUT_CYCLES < 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_READ, S_DRAIN, S_HOLD} state_t;

  state_t                    state, state_d;
  logic [31:0]               base_q;
  logic [RAM_ADDR_BITS-1:0]  addr;
  logic [RAM_ADDR_BITS-1:0]  rd_addr;
  logic                      rd_valid;
  logic                      first_wait;
  logic [15:0]               max_q;
  logic [15:0]               min_q;
  logic [SUM_W-1:0]          sum_q;
  logic [31:0]               max_n_q;
  logic                      timeout_q;
  logic                      wait_expired;

`ifdef SCAN_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state != S_WAIT) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 1'b1;
  end

  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (req) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      // done seen in the first WAIT cycle is left over from the previous run
      S_WAIT: begin
        if (!first_wait && r_done) state_d = S_READ;
        else if (wait_expired)     state_d = S_HOLD;
      end
      S_READ:   if (addr == RAM_ADDR_BITS'(RAM_WORDS - 1)) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_HOLD;
      S_HOLD:   if (res.res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    r_go          = (state == S_LAUNCH);
    r_start       = base_q;
    if (state == S_READ) r_start = {base_q[31:RAM_ADDR_BITS], addr};
    res.res_valid = (state == S_HOLD);
    res.max_count = max_q;
    res.max_n     = max_n_q;
    res.min_count = min_q;
    res.sum_count = sum_q;
    res.timeout   = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      base_q     <= '0;
      addr       <= '0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      first_wait <= 1'b0;
      max_q      <= '0;
      min_q      <= '0;
      sum_q      <= '0;
      max_n_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state    <= state_d;
      rd_valid <= (state == S_READ);
      rd_addr  <= addr;
      case (state)
        S_IDLE: if (req) base_q <= base;
        S_LAUNCH: begin
          max_q      <= '0;
          min_q      <= '1;
          sum_q      <= '0;
          max_n_q    <= base_q;
          addr       <= '0;
          first_wait <= 1'b1;
        end
        S_WAIT: begin
          first_wait <= 1'b0;
          if (state_d == S_HOLD) begin
            max_q     <= '0;
            min_q     <= '0;
            sum_q     <= '0;
            max_n_q   <= '0;
            timeout_q <= 1'b1;
          end
        end
        S_READ: addr <= addr + 1'b1;
        S_HOLD: if (res.res_ready) timeout_q <= 1'b0;
        default: ;
      endcase
      // RAM read is registered: data arriving now belongs to last cycle's address
      if (rd_valid) begin
        sum_q <= sum_q + SUM_W'(r_count);
        if (r_count > max_q) begin
          max_q   <= r_count;
          max_n_q <= base_q + 32'(rd_addr);
        end
        if (r_count < min_q) min_q <= r_count;
      end
    end
  end

endmodule

// File: tb/tb_range_scan.sv
// Directed bench for range_scan with a behavioural model of the `range` Collatz block.
module tb_range_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] base;
  logic        busy;
  logic        r_go;
  logic [31:0] r_start;
  logic        r_done = 1'b0;
  logic [15:0] r_count = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  range_scan_if #(.RAM_ADDR_BITS(4)) res ();

  range_scan #(.RAM_WORDS(16), .RAM_ADDR_BITS(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .base(base), .busy(busy), .res(res),
    .r_go(r_go), .r_start(r_start), .r_done(r_done), .r_count(r_count)
  );

  // range model
  logic [15:0] mem [16];
  int unsigned cnt = 0;
  bit clr_pend = 1'b0;
  bit stale_mode = 1'b0;
  bit never_done = 1'b0;
  bit const_mode = 1'b0;

  function automatic logic [15:0] collatz(input logic [31:0] n);
    logic [31:0] x;
    int steps;
    x = n;
    steps = 0;
    if (x == 0) return 16'd0;
    while (x != 1) begin
      if (x[0]) x = 3 * x + 1;
      else      x = x >> 1;
      steps++;
    end
    return 16'(steps);
  endfunction

  always @(posedge clk) begin
    r_count <= mem[r_start[3:0]];
    if (r_go) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= const_mode ? 16'd5 : collatz(r_start + 32'(i));
      cnt      <= 3;
      clr_pend <= 1'b1;
      if (!stale_mode) r_done <= 1'b0;
    end else if (clr_pend) begin
      clr_pend <= 1'b0;
      r_done   <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !never_done) r_done <= 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [31:0] b);
    base = b;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res.res_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic handshake;
    res.res_ready = 1'b1;
    tick();
    res.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 1'b0;
    base = 32'hDEAD_BEEF;
    res.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick();
    tick();
    checks++; if ({busy, res.res_valid, r_go, res.timeout} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {busy, res.res_valid, r_go, res.timeout}); end
    checks++; if (r_start !== 32'd0 || res.max_n !== 32'd0) begin failures++;
      $display("FAIL reset_words got r_start=%0h max_n=%0h exp=0", r_start, res.max_n); end
    checks++; if (res.max_count !== 16'd0 || res.min_count !== 16'd0 || res.sum_count !== 20'd0) begin failures++;
      $display("FAIL reset_acc got max=%0d min=%0d sum=%0d exp=0", res.max_count, res.min_count, res.sum_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_collatz;
    int cyc;
    const_mode = 1'b0;
    start_scan(32'd1);
    wait_valid(cyc);
    checks++; if (cyc !== 23) begin failures++; $display("FAIL collatz_latency got=%0d exp=23", cyc); end
    checks++; if (res.max_count !== 16'd19) begin failures++; $display("FAIL collatz_max got=%0d exp=19", res.max_count); end
    checks++; if (res.max_n !== 32'd9) begin failures++; $display("FAIL collatz_max_n got=%0d exp=9", res.max_n); end
    checks++; if (res.min_count !== 16'd0) begin failures++; $display("FAIL collatz_min got=%0d exp=0", res.min_count); end
    checks++; if (res.sum_count !== 20'd137) begin failures++; $display("FAIL collatz_sum got=%0d exp=137", res.sum_count); end
    repeat (3) tick();
    checks++; if (res.res_valid !== 1'b1) begin failures++; $display("FAIL collatz_held got=%b exp=1", res.res_valid); end
    handshake();
    checks++; if ({busy, res.res_valid} !== 2'b00) begin failures++;
      $display("FAIL collatz_release got=%b exp=00", {busy, res.res_valid}); end
  endtask

  task automatic test_constant;
    int cyc;
    const_mode = 1'b1;
    start_scan(32'd100);
    wait_valid(cyc);
    checks++; if (res.res_valid !== 1'b1) begin failures++; $display("FAIL const_valid got=%b exp=1 after %0d cycles", res.res_valid, cyc); end
    checks++; if (res.max_count !== 16'd5) begin failures++; $display("FAIL const_max got=%0d exp=5", res.max_count); end
    checks++; if (res.max_n !== 32'd100) begin failures++; $display("FAIL const_max_n got=%0d exp=100", res.max_n); end
    checks++; if (res.min_count !== 16'd5) begin failures++; $display("FAIL const_min got=%0d exp=5", res.min_count); end
    checks++; if (res.sum_count !== 20'd80) begin failures++; $display("FAIL const_sum got=%0d exp=80", res.sum_count); end
  endtask

  task automatic test_back_to_back;
    int bad;
    int goes;
    int cyc;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin base = 32'd7; req = 1'b1; end
      tick();
      req = 1'b0;
      if (res.res_valid !== 1'b1 || r_go !== 1'b0 || res.max_count !== 16'd5 || res.max_n !== 32'd100 ||
          res.min_count !== 16'd5 || res.sum_count !== 20'd80) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
    handshake();
    checks++; if ({busy, res.res_valid} !== 2'b00) begin failures++;
      $display("FAIL hold_to_idle got=%b exp=00", {busy, res.res_valid}); end
    start_scan(32'd100);
    goes = 0;
    for (int i = 0; i < 4; i++) begin
      if (r_go === 1'b1) goes++;
      tick();
    end
    checks++; if (goes !== 1) begin failures++; $display("FAIL b2b_go_pulses got=%0d exp=1", goes); end
    wait_valid(cyc);
    checks++; if (res.res_valid !== 1'b1 || res.sum_count !== 20'd80) begin failures++;
      $display("FAIL b2b_result got valid=%b sum=%0d exp valid=1 sum=80", res.res_valid, res.sum_count); end
    handshake();
  endtask

  task automatic test_stale_done;
    int bad_wait;
    int bad_addr;
    logic [31:0] exp_addr;
    const_mode = 1'b0;
    stale_mode = 1'b1;
    checks++; if (r_done !== 1'b1) begin failures++; $display("FAIL stale_precond got=%b exp=1", r_done); end
    start_scan(32'h35);
    tick();
    bad_wait = 0;
    for (int i = 0; i < 5; i++) begin
      if (r_start !== 32'h35 || busy !== 1'b1) bad_wait++;
      tick();
    end
    checks++; if (bad_wait !== 0) begin failures++; $display("FAIL stale_wait got=%0d bad cycles exp=0", bad_wait); end
    bad_addr = 0;
    for (int a = 0; a < 16; a++) begin
      exp_addr = 32'h30 | 32'(a);
      if (r_start !== exp_addr) bad_addr++;
      tick();
    end
    checks++; if (bad_addr !== 0) begin failures++; $display("FAIL read_addr_order got=%0d bad cycles exp=0", bad_addr); end
    tick();
    checks++; if (res.res_valid !== 1'b1) begin failures++; $display("FAIL stale_valid got=%b exp=1", res.res_valid); end
    handshake();
    stale_mode = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int cyc;
    const_mode = 1'b0;
    start_scan(32'd1);
    repeat (13) tick();
    checks++; if (r_start !== 32'd7 || busy !== 1'b1) begin failures++;
      $display("FAIL mid_read_addr got r_start=%0d busy=%b exp r_start=7 busy=1", r_start, busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({busy, res.res_valid, r_go, res.timeout} !== 4'b0 || r_start !== 32'd0) begin failures++;
      $display("FAIL mid_reset_ctrl got=%b r_start=%0d exp=0000 r_start=0", {busy, res.res_valid, r_go, res.timeout}, r_start); end
    checks++; if (res.max_count !== 16'd0 || res.min_count !== 16'd0 || res.sum_count !== 20'd0 || res.max_n !== 32'd0) begin failures++;
      $display("FAIL mid_reset_acc got max=%0d min=%0d sum=%0d max_n=%0d exp=0", res.max_count, res.min_count, res.sum_count, res.max_n); end
    start_scan(32'd1);
    wait_valid(cyc);
    checks++; if (res.max_count !== 16'd19 || res.max_n !== 32'd9 || res.min_count !== 16'd0 || res.sum_count !== 20'd137) begin failures++;
      $display("FAIL rescan_result got max=%0d max_n=%0d min=%0d sum=%0d exp 19/9/0/137",
               res.max_count, res.max_n, res.min_count, res.sum_count); end
    handshake();
  endtask

  task automatic test_timeout;
    int cyc;
    never_done = 1'b1;
    start_scan(32'd1);
`ifdef SCAN_TIMEOUT_EN
    wait_valid(cyc);
    checks++; if (cyc !== 21 || res.timeout !== 1'b1) begin failures++;
      $display("FAIL timeout_fire got cycles=%0d timeout=%b exp cycles=21 timeout=1", cyc, res.timeout); end
    checks++; if (res.max_count !== 16'd0 || res.min_count !== 16'd0 || res.sum_count !== 20'd0 || res.max_n !== 32'd0) begin failures++;
      $display("FAIL timeout_fields got max=%0d min=%0d sum=%0d max_n=%0d exp=0", res.max_count, res.min_count, res.sum_count, res.max_n); end
    handshake();
    checks++; if ({res.timeout, res.res_valid, busy} !== 3'b000) begin failures++;
      $display("FAIL timeout_clear got=%b exp=000", {res.timeout, res.res_valid, busy}); end
`else
    cyc = 0;
    repeat (60) begin tick(); cyc++; end
    checks++; if ({busy, res.res_valid, res.timeout} !== 3'b100) begin failures++;
      $display("FAIL wait_unbounded got=%b after %0d cycles exp=100", {busy, res.res_valid, res.timeout}, cyc); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    never_done = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_collatz();
    test_constant();
    test_back_to_back();
    test_stale_done();
    test_reset_mid_read();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
